// File: rtl/push_pull_fifo_gen2_if.sv
// Push/pull handshake bundle for push_pull_fifo_gen2.
// The level and watermark signals exist only when PPFIFO_LEVEL_EN is defined.
interface push_pull_fifo_gen2_if #(
  parameter int FIFO_WORD_SIZE    = 8,
  parameter int FIFO_POINTER_BITS = 2
);
  logic                      put_req;
  logic [FIFO_WORD_SIZE-1:0] put_value;
  logic                      put_ack;
  logic                      get_req;
  logic                      get_ack;
  logic [FIFO_WORD_SIZE-1:0] get_value;
`ifdef PPFIFO_LEVEL_EN
  logic [FIFO_POINTER_BITS:0] level;
  logic                       almost_full;
  logic                       almost_empty;

  modport master (output put_req, put_value, get_req,
                  input  put_ack, get_ack, get_value, level, almost_full, almost_empty);
  modport slave  (input  put_req, put_value, get_req,
                  output put_ack, get_ack, get_value, level, almost_full, almost_empty);
`else
  modport master (output put_req, put_value, get_req,
                  input  put_ack, get_ack, get_value);
  modport slave  (input  put_req, put_value, get_req,
                  output put_ack, get_ack, get_value);
`endif
endinterface

// File: rtl/push_pull_fifo_gen2.sv
// Circular-buffer FIFO with registered one-cycle put/get acks and an ack-gap rule.
// Define PPFIFO_LEVEL_EN to add the level counter and almost_full/almost_empty flags.
module push_pull_fifo_gen2 #(
  parameter int FIFO_WORD_SIZE    = 8,
  parameter int FIFO_POINTER_BITS = 2,
  parameter int AF_LEVEL          = (1 << FIFO_POINTER_BITS) - 1,
  parameter int AE_LEVEL          = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  push_pull_fifo_gen2_if.slave bus
);
  localparam int PB    = FIFO_POINTER_BITS;
  localparam int DEPTH = 1 << PB;
  localparam logic [PB:0] PTR_ONE = 1;

  logic [FIFO_WORD_SIZE-1:0] mem [DEPTH];
  logic [PB:0]               wr_ptr, rd_ptr;
  logic                      full, empty, put_fire, get_fire;

  // Extra MSB distinguishes full (wrap bits differ) from empty (identical).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PB] != rd_ptr[PB]) && (wr_ptr[PB-1:0] == rd_ptr[PB-1:0]);

  // A pending ack blocks the same port for one cycle; no pass-through between ports.
  assign put_fire = bus.put_req && !full  && !bus.put_ack && !clear;
  assign get_fire = bus.get_req && !empty && !bus.get_ack && !clear;

  always_ff @(posedge clock)
    if (put_fire) mem[wr_ptr[PB-1:0]] <= bus.put_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.put_ack   <= 1'b0;
      bus.get_ack   <= 1'b0;
      bus.get_value <= '0;
    end else if (clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.put_ack   <= 1'b0;
      bus.get_ack   <= 1'b0;
      bus.get_value <= '0;
    end else begin
      if (put_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (get_fire) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        bus.get_value <= mem[rd_ptr[PB-1:0]];
      end
      bus.put_ack <= put_fire;
      bus.get_ack <= get_fire;
    end
  end

`ifdef PPFIFO_LEVEL_EN
  logic [PB:0] level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      level_q <= '0;
    else if (clear) level_q <= '0;
    else            level_q <= level_q + {{PB{1'b0}}, put_fire} - {{PB{1'b0}}, get_fire};
  end

  assign bus.level        = level_q;
  assign bus.almost_full  = (int'(level_q) >= AF_LEVEL);
  assign bus.almost_empty = (int'(level_q) <= AE_LEVEL);
`endif
endmodule

// File: tb/tb_push_pull_fifo_gen2.sv
// Self-checking bench for push_pull_fifo_gen2: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_push_pull_fifo_gen2;
  localparam int W = 8, PB = 2, DEPTH = 4;

  logic clock = 1'b0;
  logic reset, clear;
  int   checks = 0, failures = 0, cyc = 0;

  push_pull_fifo_gen2_if #(.FIFO_WORD_SIZE(W), .FIFO_POINTER_BITS(PB)) bus ();
  push_pull_fifo_gen2 #(.FIFO_WORD_SIZE(W), .FIFO_POINTER_BITS(PB)) dut (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus.slave));

  always #5 clock = ~clock;

  // Reference model: queue of stored words plus the two registered acks.
  logic [W-1:0] q[$];
  bit           m_pack, m_gack;
  logic [W-1:0] m_gval;

  task automatic model_reset();
    q.delete(); m_pack = 0; m_gack = 0; m_gval = '0;
  endtask

  task automatic step();
    bit full, empty, pf, gf;
    @(posedge clock);
    cyc++;
    if (reset || clear) model_reset();
    else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      pf = bus.put_req && !full  && !m_pack;
      gf = bus.get_req && !empty && !m_gack;
      if (gf) m_gval = q.pop_front();
      if (pf) q.push_back(bus.put_value);
      m_pack = pf; m_gack = gf;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; clear = 0; bus.put_req = 0; bus.get_req = 0; bus.put_value = '0;
    #3;
    checks++; if (bus.put_ack !== 1'b0) begin failures++; $display("FAIL reset_put_ack got=%b exp=0", bus.put_ack); end
    checks++; if (bus.get_ack !== 1'b0) begin failures++; $display("FAIL reset_get_ack got=%b exp=0", bus.get_ack); end
    checks++; if (bus.get_value !== 8'h00) begin failures++; $display("FAIL reset_get_value got=%h exp=00", bus.get_value); end
`ifdef PPFIFO_LEVEL_EN
    checks++; if (bus.level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin failures++;
      $display("FAIL reset_flags got=ae%b af%b exp=ae1 af0", bus.almost_empty, bus.almost_full); end
`endif
    model_reset();
    step(); step();
    reset = 0;
  endtask

  task automatic test_fill();
    logic [W-1:0] vals [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    int ack_cyc[$];
    int idx = 0;
    bus.put_req = 1; bus.put_value = vals[0];
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (bus.put_ack !== m_pack) begin failures++; $display("FAIL fill_put_ack cyc=%0d got=%b exp=%b", cyc, bus.put_ack, m_pack); end
      if (bus.put_ack) begin
        ack_cyc.push_back(cyc); idx++;
        if (idx < 5) bus.put_value = vals[idx];
      end
    end
    checks++; if (ack_cyc.size() != 4) begin failures++; $display("FAIL fill_ack_count got=%0d exp=4", ack_cyc.size()); end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      checks++; if (ack_cyc[i] - ack_cyc[i-1] != 2) begin failures++; $display("FAIL fill_ack_gap got=%0d exp=2", ack_cyc[i] - ack_cyc[i-1]); end
    end
`ifdef PPFIFO_LEVEL_EN
    checks++; if (bus.level !== 3'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", bus.level); end
    checks++; if (bus.almost_full !== 1'b1) begin failures++; $display("FAIL fill_almost_full got=%b exp=1", bus.almost_full); end
`endif
  endtask

  // Starts full with 0xA5 still pending on the put port.
  task automatic test_drain();
    logic [W-1:0] exp [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [W-1:0] got[$];
    int gcyc[$];
    int pcyc = -1;
    bus.get_req = 1;
    for (int i = 0; i < 40 && got.size() < 5; i++) begin
      step();
      checks++; if (bus.put_ack !== m_pack || bus.get_ack !== m_gack) begin failures++;
        $display("FAIL drain_acks cyc=%0d got=p%b g%b exp=p%b g%b", cyc, bus.put_ack, bus.get_ack, m_pack, m_gack); end
      if (bus.put_ack) begin pcyc = cyc; bus.put_req = 0; end
      if (bus.get_ack) begin got.push_back(bus.get_value); gcyc.push_back(cyc); end
    end
    bus.get_req = 0;
    checks++; if (got.size() != 5) begin failures++; $display("FAIL drain_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    for (int i = 1; i < 4 && i < gcyc.size(); i++) begin
      checks++; if (gcyc[i] - gcyc[i-1] != 2) begin failures++; $display("FAIL drain_gap got=%0d exp=2", gcyc[i] - gcyc[i-1]); end
    end
    if (gcyc.size() > 0) begin
      checks++; if (pcyc != gcyc[0] + 1) begin failures++; $display("FAIL drain_a5_accept got=%0d exp=%0d", pcyc, gcyc[0] + 1); end
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] got[$];
    int v = 0;
    bus.put_req = 1; bus.get_req = 1; bus.put_value = '0;
    for (int i = 0; i < 120 && got.size() < 10; i++) begin
      step();
      checks++; if (bus.put_ack !== m_pack || bus.get_ack !== m_gack) begin failures++;
        $display("FAIL stream_acks cyc=%0d got=p%b g%b exp=p%b g%b", cyc, bus.put_ack, bus.get_ack, m_pack, m_gack); end
`ifdef PPFIFO_LEVEL_EN
      checks++; if (int'(bus.level) > DEPTH || int'(bus.level) != q.size()) begin failures++;
        $display("FAIL stream_level got=%0d exp=%0d", bus.level, q.size()); end
`endif
      if (bus.put_ack) begin
        v++;
        if (v < 10) bus.put_value = W'(v); else bus.put_req = 0;
      end
      if (bus.get_ack) got.push_back(bus.get_value);
    end
    bus.get_req = 0; bus.put_req = 0;
    checks++; if (got.size() != 10) begin failures++; $display("FAIL stream_count got=%0d exp=10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== W'(i)) begin failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], W'(i)); end
    end
  endtask

  // Empty FIFO: the get must not see the word in the cycle it is written.
  task automatic test_passthru();
    bus.put_value = 8'h5A; bus.put_req = 1; bus.get_req = 1;
    step();
    checks++; if (bus.put_ack !== 1'b1 || bus.get_ack !== 1'b0) begin failures++;
      $display("FAIL passthru_first got=p%b g%b exp=p1 g0", bus.put_ack, bus.get_ack); end
    bus.put_req = 0;
    step();
    checks++; if (bus.get_ack !== 1'b1 || bus.get_value !== 8'h5A) begin failures++;
      $display("FAIL passthru_get got=g%b %h exp=g1 5a", bus.get_ack, bus.get_value); end
    step();
    checks++; if (bus.get_ack !== 1'b0) begin failures++; $display("FAIL passthru_empty got=%b exp=0", bus.get_ack); end
    bus.get_req = 0;
  endtask

  task automatic test_clear();
    logic [W-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    int idx = 0;
    bus.put_req = 1; bus.put_value = vals[0];
    for (int i = 0; i < 20 && idx < 3; i++) begin
      step();
      if (bus.put_ack) begin idx++; if (idx < 3) bus.put_value = vals[idx]; end
    end
    checks++; if (idx != 3) begin failures++; $display("FAIL clear_load got=%0d exp=3", idx); end
    bus.put_value = 8'h44; clear = 1;
    step();
    clear = 0; bus.put_req = 0;
    checks++; if (bus.put_ack !== 1'b0 || bus.get_ack !== 1'b0 || bus.get_value !== 8'h00) begin failures++;
      $display("FAIL clear_outputs got=p%b g%b %h exp=p0 g0 00", bus.put_ack, bus.get_ack, bus.get_value); end
`ifdef PPFIFO_LEVEL_EN
    checks++; if (bus.level !== 3'd0 || bus.almost_empty !== 1'b1) begin failures++;
      $display("FAIL clear_level got=%0d ae%b exp=0 ae1", bus.level, bus.almost_empty); end
`endif
    bus.get_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.get_ack !== 1'b0) begin failures++; $display("FAIL clear_get_stall cyc=%0d got=%b exp=0", cyc, bus.get_ack); end
    end
    bus.put_value = 8'h55; bus.put_req = 1;
    idx = 0;
    for (int i = 0; i < 10 && !bus.get_ack; i++) begin
      step();
      if (bus.put_ack) bus.put_req = 0;
    end
    bus.get_req = 0; bus.put_req = 0;
    checks++; if (bus.get_ack !== 1'b1 || bus.get_value !== 8'h55) begin failures++;
      $display("FAIL clear_new_word got=g%b %h exp=g1 55", bus.get_ack, bus.get_value); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] vals [3] = '{8'h66, 8'h77, 8'h88};
    int idx = 0;
    step();
    bus.put_req = 1; bus.put_value = vals[0];
    for (int i = 0; i < 20 && idx < 3; i++) begin
      step();
      if (bus.put_ack) begin idx++; if (idx < 3) bus.put_value = vals[idx]; else bus.put_req = 0; end
    end
    bus.put_req = 0; bus.get_req = 1;
    for (int i = 0; i < 10 && !bus.get_ack; i++) step();
    bus.get_req = 0;
    checks++; if (bus.get_ack !== 1'b1 || bus.get_value !== 8'h66) begin failures++;
      $display("FAIL areset_pre got=g%b %h exp=g1 66", bus.get_ack, bus.get_value); end
    #2 reset = 1;
    #1;
    checks++; if (bus.get_ack !== 1'b0 || bus.get_value !== 8'h00 || bus.put_ack !== 1'b0) begin failures++;
      $display("FAIL areset_outputs got=p%b g%b %h exp=p0 g0 00", bus.put_ack, bus.get_ack, bus.get_value); end
`ifdef PPFIFO_LEVEL_EN
    checks++; if (bus.level !== 3'd0 || bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin failures++;
      $display("FAIL areset_level got=%0d ae%b af%b exp=0 ae1 af0", bus.level, bus.almost_empty, bus.almost_full); end
`endif
    model_reset();
    #1 reset = 0;
    bus.get_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.get_ack !== 1'b0) begin failures++; $display("FAIL areset_get_stall cyc=%0d got=%b exp=0", cyc, bus.get_ack); end
    end
    bus.get_req = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!bus.put_req || bus.put_ack) begin bus.put_req = 1'($urandom_range(0, 1)); bus.put_value = W'($urandom); end
      if (!bus.get_req || bus.get_ack) bus.get_req = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 31) == 0);
      step();
      checks++; if (bus.put_ack !== m_pack || bus.get_ack !== m_gack || bus.get_value !== m_gval) begin failures++;
        $display("FAIL random cyc=%0d got=p%b g%b %h exp=p%b g%b %h", cyc, bus.put_ack, bus.get_ack, bus.get_value, m_pack, m_gack, m_gval); end
`ifdef PPFIFO_LEVEL_EN
      checks++; if (int'(bus.level) != q.size() || bus.almost_full !== (q.size() >= DEPTH - 1) || bus.almost_empty !== (q.size() <= 1)) begin failures++;
        $display("FAIL random_level cyc=%0d got=%0d af%b ae%b exp=%0d", cyc, bus.level, bus.almost_full, bus.almost_empty, q.size()); end
`endif
    end
    clear = 0; bus.put_req = 0; bus.get_req = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_passthru();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
